// File: rtl/ram_loader_pkg.sv
// Shared FSM encodings and depth helper for the run-time loaded lookup RAM.
package ram_loader_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   function automatic int unsigned depth_of(input int unsigned n);
      return 32'd1 << n;
   endfunction

endpackage

// File: rtl/ram_core.sv
// 2^N x M storage: write on the clock edge when we is high; read is combinational.
// The array is deliberately not reset, so a reset mid-load keeps the words already written.
module ram_core #(
   parameter int N = 3,
   parameter int M = 16
) (
   input  logic         clk,
   input  logic         we,
   input  logic [N-1:0] waddr,
   input  logic [M-1:0] wdata,
   input  logic [N-1:0] raddr,
   output logic [M-1:0] rdata
);

   logic [M-1:0] mem [2**N];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // No write-to-read bypass: a same-address read shows the new word only after the edge.
   assign rdata = mem[raddr];

endmodule

// File: rtl/ram_loader.sv
// Streams valid/ready words into ram_core at addresses 0,1,2,... and exposes a combinational read port.
// The first word can be accepted 1 cycle after start, and done pulses 1 cycle after the final word is written.
// wr_ready is high for the whole of LOAD, so the source sets the pace; nothing is accepted outside LOAD.
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int N = 3,
   parameter int M = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         wr_valid,
   input  logic [M-1:0] wr_data,
   input  logic         wr_last,
   output logic         wr_ready,
   output logic         busy,
   output logic         done,
   output logic [N:0]   wr_count,
   input  logic [N-1:0] rd_addr,
   output logic [M-1:0] rd_data
);

   localparam int         DEPTH    = int'(depth_of(N));
   localparam logic [N:0] CNT_LAST = (N+1)'(DEPTH - 1);

   logic [1:0]   state_q, state_d;
   logic [N-1:0] ptr_q, ptr_d;
   logic [N:0]   cnt_q, cnt_d;
   logic         xfer;

   assign xfer = wr_valid && (state_q == S_LOAD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         // The DEPTH-th word ends the session even if the source never raises wr_last.
         S_LOAD:  if (xfer && (wr_last || cnt_q == CNT_LAST)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_ready = (state_q == S_LOAD);
      busy     = (state_q == S_LOAD);
      done     = (state_q == S_DONE);
   end

   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      if (state_q == S_IDLE && start) begin
         ptr_d = '0;
         cnt_d = '0;
      end else if (xfer) begin
         ptr_d = ptr_q + 1'b1;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end

   assign wr_count = cnt_q;

   ram_core #(.N(N), .M(M)) u_core (
      .clk   (clk),
      .we    (xfer),
      .waddr (ptr_q),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: directed scenarios plus random sessions checked against a behavioural model.
module tb_ram_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        wr_valid = 1'b0;
   logic [15:0] wr_data = '0;
   logic        wr_last = 1'b0;
   logic        wr_ready, busy, done;
   logic [3:0]  wr_count;
   logic [2:0]  rd_addr = '0;
   logic [15:0] rd_data;

   int vectors = 0;
   int miscompares = 0;

   // Behavioural model: session flags, word count, next address, memory image.
   bit          loading = 0;
   bit          finishing = 0;
   int          m_cnt = 0;
   int          m_ptr = 0;
   logic [15:0] mem_m [8];
   bit          known [8];

   ram_loader #(.N(3), .M(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .wr_valid (wr_valid),
      .wr_data  (wr_data),
      .wr_last  (wr_last),
      .wr_ready (wr_ready),
      .busy     (busy),
      .done     (done),
      .wr_count (wr_count),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            loading = 0;
            finishing = 0;
            m_cnt = 0;
            m_ptr = 0;
         end else if (finishing) begin
            finishing = 0;
         end else if (loading) begin
            if (wr_valid) begin
               mem_m[m_ptr] = wr_data;
               known[m_ptr] = 1;
               m_ptr = (m_ptr + 1) % 8;
               m_cnt = m_cnt + 1;
               if (wr_last || m_cnt == 8) begin
                  loading = 0;
                  finishing = 1;
               end
            end
         end else if (start) begin
            loading = 1;
            m_cnt = 0;
            m_ptr = 0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         chk("wr_ready", wr_ready, loading);
         chk("busy", busy, loading);
         chk("done", done, finishing);
         chk("wr_count", wr_count, m_cnt);
         if (known[rd_addr]) chk("rd_data", rd_data, mem_m[rd_addr]);
      end
   end

   task automatic drive(input logic s, input logic v, input logic [15:0] d, input logic l);
      @(posedge clk);
      #2;
      start = s;
      wr_valid = v;
      wr_data = d;
      wr_last = l;
   endtask

   task automatic read_at(input int a, input logic [15:0] exp);
      @(posedge clk);
      #2;
      rd_addr = 3'(a);
      @(negedge clk);
      chk("rd_sweep", rd_data, exp);
   endtask

   logic [15:0] full_img [8];
   logic [15:0] bp_words [3];
   logic [15:0] rst_words [3];

   initial begin
      int wi;
      bit seen;
      full_img = '{16'h1234, 16'h5678, 16'hABCD, 16'hEEFF, 16'h78CD, 16'hAB23, 16'h5566, 16'h2299};

      // Reset state and IDLE ignoring wr_valid
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", wr_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_count", wr_count, 0);
      repeat (3) drive(0, 1, 16'hDEAD, 0);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("idle_count", wr_count, 0);
      chk("idle_ready", wr_ready, 0);

      // Full load of 8 words without wr_last
      drive(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) drive(0, 1, full_img[i], 0);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("full_done", done, 1);
      chk("full_count", wr_count, 4'd8);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("full_done_1cyc", done, 0);
      chk("full_count_hold", wr_count, 4'd8);
      for (int i = 0; i < 8; i++) read_at(i, full_img[i]);

      // Short load terminated by wr_last
      drive(1, 0, 0, 0);
      drive(0, 1, 16'hCAFE, 0);
      drive(0, 1, 16'hBEEF, 1);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("short_done", done, 1);
      chk("short_count", wr_count, 4'd2);
      read_at(0, 16'hCAFE);
      read_at(1, 16'hBEEF);
      for (int i = 2; i < 8; i++) read_at(i, full_img[i]);

      // Same-address write/read collision
      @(posedge clk);
      #2 rd_addr = 3'd0;
      drive(1, 0, 0, 0);
      drive(0, 1, 16'h0F0F, 1);
      @(negedge clk);
      chk("coll_before", rd_data, 16'hCAFE);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("coll_after", rd_data, 16'h0F0F);
      chk("coll_done", done, 1);

      // Valid gaps plus an ignored start during LOAD
      drive(1, 0, 0, 0);
      wi = 0;
      for (int i = 0; i < 6; i++) begin
         bit v;
         logic [15:0] d;
         v = (i == 0 || i == 3 || i == 5);
         d = 16'($urandom);
         if (v) begin
            bp_words[wi] = d;
            wi++;
         end
         drive((i == 2) ? 1'b1 : 1'b0, v, d, 0);
      end
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("bp_count", wr_count, 4'd3);
      chk("bp_busy", busy, 1);
      for (int i = 0; i < 3; i++) read_at(i, bp_words[i]);
      drive(0, 1, 16'h4242, 1);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("bp_done", done, 1);
      chk("bp_final_count", wr_count, 4'd4);

      // Random sessions
      for (int s = 0; s < 40; s++) begin
         drive(1, 1'($urandom_range(0, 1)), 16'($urandom), 0);
         for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #2;
            start    = loading ? 1'($urandom_range(0, 1)) : 1'b0;
            wr_valid = 1'($urandom_range(0, 3) != 0);
            wr_data  = 16'($urandom);
            wr_last  = ($urandom_range(0, 6) == 0);
            rd_addr  = 3'($urandom_range(0, 7));
         end
         drive(0, 0, 0, 0);
         drive(0, 0, 0, 0);
      end

      // Asynchronous reset in the middle of a load
      drive(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         rst_words[i] = 16'($urandom);
         drive(0, 1, rst_words[i], 0);
      end
      @(posedge clk);
      #2 wr_valid = 1'b0;
      @(negedge clk);
      chk("mid_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_ready", wr_ready, 0);
      chk("mid_busy", busy, 0);
      chk("mid_count", wr_count, 0);
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("mid_no_done", seen, 0);
      for (int i = 0; i < 3; i++) read_at(i, rst_words[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL timeout: bench did not complete, expected finish before t=900000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ram_loader.md
Name: ram_loader

Overview:
- Write-side counterpart to the team's combinational-read ROM. It accepts a stream of words over a valid/ready handshake and writes them into an internal 2^N x M memory at sequential addresses starting from 0.
- It exposes the same combinational read port (address in, data out) that downstream logic already uses for the ROM, so the memory image is loaded at run time instead of fixed at elaboration.
- It sits between a data source (UART receiver, testbench, host interface) and any consumer of a lookup table.

Parameters:
N, 3, address width; memory depth DEPTH = 2**N words
M, 16, data word width in bits

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start  input  1  one-cycle pulse; begins a load session (honoured only in IDLE)
wr_valid  input  1  source has a word on wr_data
wr_data  input  M  word to write
wr_last  input  1  qualifies the final word of the session; sampled with wr_valid
wr_ready  output  1  loader accepts a word this cycle
busy  output  1  high while in LOAD
done  output  1  one-cycle pulse when a session completes
wr_count  output  N+1  number of words written in the current or last session
rd_addr  input  N  read address
rd_data  output  M  mem[rd_addr], combinational

Behaviour:
- FSM states: IDLE, LOAD, DONE (2-bit encoding).
- Reset (asynchronous, rst_n=0):
  - state=IDLE, write pointer=0, wr_count=0.
  - wr_ready=0, busy=0, done=0.
  - Memory contents are not reset: they are undefined until written and retained across reset.
- IDLE:
  - wr_ready=0.
  - start=1 -> LOAD on the next edge; pointer and wr_count cleared to 0 on that edge.
  - wr_valid is ignored.
- LOAD:
  - wr_ready=1 and busy=1, both driven combinationally from state.
  - Transfer occurs when wr_valid && wr_ready at a rising edge: mem[ptr] <= wr_data, ptr <= ptr+1, wr_count <= wr_count+1.
  - No transfer occurs when wr_valid=0; the FSM holds.
  - Transfer with wr_last=1 -> DONE.
  - Transfer of the DEPTH-th word (wr_count == DEPTH-1 before the edge) -> DONE, whether or not wr_last is set. The pointer wraps to 0 and is never used to write again in this session.
  - start is ignored in LOAD.
- DONE:
  - done=1 and wr_ready=0 for exactly one cycle, then -> IDLE unconditionally.
  - start is ignored in DONE; the source must reissue start in IDLE.
- wr_count:
  - Holds its final value (1..DEPTH) through IDLE until the next accepted start.
  - N+1 bits wide so that DEPTH is representable, e.g. 8 -> 4'b1000.
- Read port:
  - Asynchronous read of the same array; rd_data = mem[rd_addr] at all times, including during LOAD.
  - Write/read collision on the same address: rd_data shows the old word until the write edge, then the new word. There is no bypass.
- Reset mid-LOAD:
  - Returns to IDLE immediately. Words already written stay in memory; wr_count clears.
  - No done pulse is produced.
- Latency:
  - start -> wr_ready high: 1 cycle.
  - Final transfer -> done: 1 cycle.
  - Written word visible on rd_data in the cycle after its transfer edge.

Decomposition:
- Shared package ram_loader_pkg: state localparams S_IDLE=2'd0, S_LOAD=2'd1, S_DONE=2'd2, plus the DEPTH = 2**N helper.
- One sub-module, ram_core #(N,M): synchronous write (we, waddr, wdata), asynchronous read (raddr -> rdata).
- ram_loader contains only the FSM, pointer and counter, and instantiates ram_core.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then release.
  - Required: wr_ready=0, busy=0, done=0, wr_count=0. Driving wr_valid=1 with wr_data=16'hDEAD in IDLE gives no write and wr_count stays 0.
- Full load: pulse start, then stream 1234,5678,ABCD,EEFF,78CD,AB23,5566,2299 (hex) with wr_valid held high and wr_last=0.
  - Required: done pulses exactly 1 cycle after the 8th word and wr_count=4'd8.
  - Sweeping rd_addr 0..7 then returns that sequence.
- Short load: start, send 16'hCAFE and 16'hBEEF with wr_last=1 on the second word.
  - Required: done after the 2nd word, wr_count=2, mem[0]=CAFE, mem[1]=BEEF.
  - mem[2..7] keep their prior contents from the full load.
- Backpressure gaps: during LOAD toggle wr_valid 1,0,0,1,0,1.
  - Required: exactly 3 writes to addresses 0,1,2.
  - A second start during LOAD has no effect (wr_count not cleared).
- Collision: rd_addr=0 while writing 16'h0F0F to address 0.
  - Required: rd_data shows the old word before the edge and 0F0F after it.
- Reset mid-LOAD: after 3 words, assert rst_n=0 asynchronously between edges.
  - Required: wr_ready and busy drop immediately, no done pulse, wr_count=0.
  - mem[0..2] still hold the 3 written words.
